// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared definitions for the EX/MEM flag stage and the branch condition evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_mem_flag_stage_pkg;

  // Bit positions inside the {N,Z,V} flag vector (ALU Flags order).
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  // Branch condition encodings.
  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  // Stage control state: HALTED is left only through reset.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } stage_state_t;

endpackage

// File: rtl/ex_mem_flag_stage_branch_cond_eval.sv
// Branch condition evaluator: 3-bit condition code + {N,Z,V} flags -> taken.
// Latency: 0 (pure combinational); also instantiated by decode.
// Backpressure: none.
// Ports: cond (condition code), flags ({N,Z,V}), taken (condition holds).
module branch_cond_eval
  import ex_mem_flag_stage_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n;
  logic z;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM stage register, architectural N/Z/V flag register and branch resolve.
// Latency: 1 cycle EX->MEM; br_taken is combinational with a same-cycle flag bypass.
// Backpressure: stall holds every register; flush or an invalid/halted EX inserts a bubble.
// Ports: clk/rst; ex_* EX-side instruction, flags and control; stall/flush pipeline control;
//        br_cond decode branch condition; mem_* registered MEM-side copies; flags_q flag
//        register; br_taken branch resolution; halted sticky halt status.
module ex_mem_flag_stage
  import ex_mem_flag_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int FLAG_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_out,
  input  logic [FLAG_W-1:0]     ex_flags,
  input  logic [FLAG_W-1:0]     ex_flag_en,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_halt,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [2:0]            br_cond,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_alu_out,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic                  mem_halt,
  output logic [FLAG_W-1:0]     flags_q,
  output logic                  br_taken,
  output logic                  halted
);

  stage_state_t state_q;
  stage_state_t state_d;

  logic              accept;
  logic [FLAG_W-1:0] merged_flags;
  logic [FLAG_W-1:0] eff_flags;

  assign halted = (state_q == ST_HALTED);
  assign accept = ex_valid & ~stall & ~flush & ~halted;

  // Only the flags the ALU enables are overwritten; the rest keep their old value.
  assign merged_flags = (flags_q & ~ex_flag_en) | (ex_flags & ex_flag_en);

  // Bypass so a branch directly behind a flag-setting op resolves without a bubble.
  assign eff_flags = accept ? merged_flags : flags_q;

  branch_cond_eval u_branch_cond_eval (
    .cond  (br_cond),
    .flags (eff_flags),
    .taken (br_taken)
  );

  // Halt FSM: an accepted HLT parks the stage until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (accept && ex_halt) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Stage registers. Bubbles clear only the control bits; data fields keep their
  // last value since nothing downstream looks at them without mem_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_alu_out    <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
      mem_halt       <= 1'b0;
      flags_q        <= '0;
    end else if (flush || (!stall && !accept)) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_halt      <= 1'b0;
    end else if (accept) begin
      mem_valid      <= 1'b1;
      mem_alu_out    <= ex_alu_out;
      mem_rd         <= ex_rd;
      mem_reg_write  <= ex_reg_write;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_store_data <= ex_store_data;
      mem_halt       <= ex_halt;
      flags_q        <= merged_flags;
    end
    // Remaining case is a stall without flush: everything holds.
  end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_alu_out;
  logic [2:0]  ex_flags;
  logic [2:0]  ex_flag_en;
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [15:0] ex_store_data;
  logic        ex_halt;
  logic        stall;
  logic        flush;
  logic [2:0]  br_cond;
  logic        mem_valid;
  logic [15:0] mem_alu_out;
  logic [3:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [15:0] mem_store_data;
  logic        mem_halt;
  logic [2:0]  flags_q;
  logic        br_taken;
  logic        halted;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic        m_valid, m_rw, m_mr, m_mw, m_halt, m_halted;
  logic [15:0] m_alu, m_sd;
  logic [3:0]  m_rd;
  logic [2:0]  m_flags;

  ex_mem_flag_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_flags(ex_flags), .ex_flag_en(ex_flag_en), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .ex_halt(ex_halt), .stall(stall), .flush(flush),
    .br_cond(br_cond), .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data), .mem_halt(mem_halt), .flags_q(flags_q),
    .br_taken(br_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition table written from the mnemonic meanings (flags = {N,Z,V}).
  function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
    logic n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_accept();
    return ex_valid && !stall && !flush && !m_halted;
  endfunction

  function automatic logic [2:0] model_merge();
    logic [2:0] r;
    r = m_flags;
    for (int i = 0; i < 3; i++) if (ex_flag_en[i]) r[i] = ex_flags[i];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0; m_halted = 0;
    m_alu = 0; m_sd = 0; m_rd = 0; m_flags = 0;
  endtask

  task automatic model_clock();
    logic acc;
    acc = model_accept();
    if (!flush && stall) begin
      // hold everything
    end else if (acc) begin
      m_valid = 1; m_alu = ex_alu_out; m_rd = ex_rd; m_rw = ex_reg_write;
      m_mr = ex_mem_read; m_mw = ex_mem_write; m_sd = ex_store_data; m_halt = ex_halt;
      m_flags = model_merge();
      if (ex_halt) m_halted = 1;
    end else begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_valid"}, mem_valid, m_valid);
    chk({tag, ".mem_alu_out"}, mem_alu_out, m_alu);
    chk({tag, ".mem_rd"}, mem_rd, m_rd);
    chk({tag, ".mem_reg_write"}, mem_reg_write, m_rw);
    chk({tag, ".mem_mem_read"}, mem_mem_read, m_mr);
    chk({tag, ".mem_mem_write"}, mem_mem_write, m_mw);
    chk({tag, ".mem_store_data"}, mem_store_data, m_sd);
    chk({tag, ".mem_halt"}, mem_halt, m_halt);
    chk({tag, ".flags_q"}, flags_q, m_flags);
    chk({tag, ".halted"}, halted, m_halted);
  endtask

  // One cycle: check the combinational branch result, clock, then check registers.
  task automatic tick(input string tag);
    logic [2:0] eff;
    #1;
    eff = model_accept() ? model_merge() : m_flags;
    chk({tag, ".br_taken"}, br_taken, ref_taken(br_cond, eff));
    @(posedge clk);
    #1;
    model_clock();
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic idle();
    ex_valid = 0; ex_alu_out = 0; ex_flags = 0; ex_flag_en = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_store_data = 0;
    ex_halt = 0; stall = 0; flush = 0; br_cond = 0;
  endtask

  task automatic alu_op(input logic [15:0] res, input logic [2:0] f, input logic [2:0] en);
    ex_valid = 1; ex_alu_out = res; ex_flags = f; ex_flag_en = en;
    ex_rd = 4'd1; ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0; ex_halt = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    #12;
    rst = 0;
    @(negedge clk);

    // 1. Basic flag load, then an asynchronous reset in the middle of a cycle.
    alu_op(16'h00ff, 3'b101, 3'b111);
    tick("t1_add");
    chk("t1_flags_101", flags_q, 3'b101);
    chk("t1_valid", mem_valid, 1'b1);
    do_reset("t1_rst");
    chk("t1_rst_flags", flags_q, 3'b000);
    alu_op(16'h0001, 3'b101, 3'b111);
    tick("t1_add2");
    chk("t1_flags2_101", flags_q, 3'b101);

    // 2. Partial flag enable.
    alu_op(16'h0002, 3'b111, 3'b111);
    tick("t2_set");
    alu_op(16'h0003, 3'b000, 3'b010);
    tick("t2_xor");
    chk("t2_flags_101", flags_q, 3'b101);

    // 3. Bypass: result zero sets Z, EQ branch in the same cycle.
    alu_op(16'h0000, 3'b010, 3'b111);
    br_cond = 3'b001;
    #1;
    chk("t3_bypass_eq", br_taken, 1'b1);
    tick("t3_bypass");
    alu_op(16'h0005, 3'b000, 3'b111);
    tick("t3_clear");
    alu_op(16'h0000, 3'b010, 3'b111);
    stall = 1;
    #1;
    chk("t3_stall_old_flags", br_taken, 1'b0);
    tick("t3_stall");
    idle();

    // 4. Stall holds, flush+stall squashes control but keeps data.
    alu_op(16'h1234, 3'b000, 3'b000);
    ex_rd = 4'd5;
    tick("t4_load");
    for (int i = 0; i < 3; i++) begin
      alu_op(16'($urandom), 3'($urandom), 3'($urandom));
      ex_rd = 4'($urandom);
      stall = 1;
      tick("t4_stall");
      chk("t4_hold_alu", mem_alu_out, 16'h1234);
      chk("t4_hold_rd", mem_rd, 4'd5);
      chk("t4_hold_valid", mem_valid, 1'b1);
    end
    flush = 1;
    tick("t4_flush_stall");
    chk("t4_fs_valid", mem_valid, 1'b0);
    chk("t4_fs_alu", mem_alu_out, 16'h1234);
    idle();

    // 5. Halt is sticky and freezes flags until reset.
    alu_op(16'h0007, 3'b100, 3'b111);
    ex_halt = 1;
    tick("t5_halt");
    chk("t5_mem_halt", mem_halt, 1'b1);
    chk("t5_halted", halted, 1'b1);
    for (int i = 0; i < 4; i++) begin
      alu_op(16'($urandom), 3'($urandom), 3'b111);
      tick("t5_after");
      chk("t5_bubble", mem_valid, 1'b0);
      chk("t5_halt_once", mem_halt, 1'b0);
      chk("t5_frozen", flags_q, 3'b100);
    end
    do_reset("t5_rst");
    chk("t5_unhalted", halted, 1'b0);
    idle();

    // 6. Condition sweep through the bypass path, then from the stored flags.
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 8; c++) begin
        alu_op(16'(f), 3'(f), 3'b111);
        br_cond = 3'(c);
        tick("t6_bypass");
      end
      stall = 1;
      br_cond = 3'b111;
      #1;
      chk("t6_un_taken", br_taken, 1'b1);
      tick("t6_stored");
      stall = 0;
    end

    // Randomized traffic with occasional halts and mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_alu_out    = 16'($urandom);
      ex_flags      = 3'($urandom);
      ex_flag_en    = 3'($urandom);
      ex_rd         = 4'($urandom);
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = 1'($urandom);
      ex_mem_write  = 1'($urandom);
      ex_store_data = 16'($urandom);
      ex_halt       = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      br_cond       = 3'($urandom);
      tick("rnd");
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
